fft64_sched: RTL and testbench
==============================

FFT64_SCHED -- requirements
Module: fft64_sched

Interface
REQ-001 Parameter: CORE_LAT, default 2, butterfly-core latency in cycles (legal 0..7).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 val_i  input  1  input sample valid; accepted when val_i & rdy_o.
REQ-005 rdy_o  output  1  ready to accept an input sample.
REQ-006 ld_we_o  output  1  sample-memory write enable for the accepted sample.
REQ-007 ld_addr_o  output  6  bit-reversed write address for the accepted sample.
REQ-008 bf_val_o  output  1  butterfly issue strobe.
REQ-009 bf_addr_a_o / bf_addr_b_o  output  6 each  butterfly operand read addresses.
REQ-010 bf_wn_idx_o  output  5  twiddle index k of W64^k.
REQ-011 bf_stage_o  output  3  current stage, 0..5.
REQ-012 wb_val_o  output  1  butterfly result write-back strobe.
REQ-013 wb_addr_a_o / wb_addr_b_o  output  6 each  write-back addresses.
REQ-014 scale_o  output  1  divide-by-2 request to the core, aligned with bf_val_o.
REQ-015 rd_en_o  output  1  result read enable.
REQ-016 rd_addr_o  output  6  natural-order result read address.
REQ-017 val_o  output  1  result valid, one cycle after rd_en_o.
REQ-018 busy_o  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, LOAD, CALC, DRAIN, OUT.
REQ-020 IDLE and LOAD: rdy_o=1; all other states: rdy_o=0, and val_i is ignored.
REQ-021 Sample counter n (0..63) advances on each accepted sample; ld_we_o = val_i & rdy_o (combinational); ld_addr_o = bitrev6(n).
REQ-022 IDLE->LOAD on the first accepted sample; gaps in val_i hold n.
REQ-023 LOAD->CALC on the 64th accepted sample (n wraps to 0).
REQ-024 CALC issues one butterfly per cycle, k = 0..31, with bf_val_o=1 every cycle; the first issue occurs the cycle after the 64th sample.
REQ-025 Butterfly addressing for stage s and issue k: h = 2^s; a = (k>>s)*2h + (k & (h-1)); b = a + h.
REQ-026 Twiddle index for stage s and issue k: wn = (k & (h-1)) << (5-s).
REQ-027 After k=31, CALC->DRAIN for exactly CORE_LAT cycles with bf_val_o=0; CORE_LAT=0 skips DRAIN.
REQ-028 DRAIN exits to CALC with s+1 when s<5, or to OUT when s=5.
REQ-029 wb_val_o and wb_addr_a_o/wb_addr_b_o equal bf_val_o and bf_addr_a_o/bf_addr_b_o delayed by exactly CORE_LAT cycles; with CORE_LAT=0 they are combinational copies.
REQ-030 OUT asserts rd_en_o for 64 consecutive cycles with rd_addr_o = 0..63.
REQ-031 val_o is rd_en_o registered; the FSM returns to IDLE after the last rd_en_o; busy_o stays high until the final val_o.
REQ-032 Latency from the cycle after the 64th sample to the first rd_en_o is 6*(32+CORE_LAT) cycles (204 at default).
REQ-033 Address and index outputs hold their last value while the matching strobe is low.

Reset
REQ-034 rst forces IDLE; n, k and s cleared; the write-back delay line is flushed.
REQ-035 During rst, every output except rdy_o is 0; rdy_o=1 after reset.
REQ-036 rst asserted mid-operation aborts the transform with no further wb_val_o or val_o pulses.

Configuration
REQ-037 Macro FFT64_SCHED_SCALE_EN defined: scale_o = bf_val_o, i.e. 1/2 per stage and 1/64 total.
REQ-038 Macro FFT64_SCHED_SCALE_EN undefined: scale_o tied to 0; all other behaviour is identical.

Verification
REQ-039 Reset, then 64 back-to-back samples -> ld_addr_o = 0,32,16,48,8,...,63; rdy_o falls the cycle after the 64th sample.
REQ-040 Stage checks -> s0 k0: a=0, b=1, wn=0; s1 k1: a=1, b=3, wn=16; s5 k1: a=1, b=33, wn=1; s5 k31: a=31, b=63, wn=31.
REQ-041 CORE_LAT=2 -> first rd_en_o 204 cycles after the first bf_val_o; each wb_val_o exactly 2 cycles after its bf_val_o; no bf_val_o during DRAIN.
REQ-042 val_i toggling 1/0 during LOAD -> 64 ld_we_o pulses only; val_i held high during CALC/OUT -> no ld_we_o.
REQ-043 rst pulsed at stage 3 k=10 -> all strobes 0 immediately, busy_o=0, rdy_o=1; a following full load behaves as REQ-039.
REQ-044 FFT64_SCHED_SCALE_EN defined -> scale_o has 192 pulses per transform; undefined -> scale_o constantly 0.

Source files
------------

// File: rtl/fft64_sched.sv
// fft64_sched: load / butterfly / read-out scheduler for an in-place radix-2 64-point FFT.
// Define FFT64_SCHED_SCALE_EN to request a divide-by-2 from the core on every butterfly.
module fft64_sched #(
    parameter int unsigned CORE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       val_i,
    output logic       rdy_o,
    output logic       ld_we_o,
    output logic [5:0] ld_addr_o,
    output logic       bf_val_o,
    output logic [5:0] bf_addr_a_o,
    output logic [5:0] bf_addr_b_o,
    output logic [4:0] bf_wn_idx_o,
    output logic [2:0] bf_stage_o,
    output logic       wb_val_o,
    output logic [5:0] wb_addr_a_o,
    output logic [5:0] wb_addr_b_o,
    output logic       scale_o,
    output logic       rd_en_o,
    output logic [5:0] rd_addr_o,
    output logic       val_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, OUT} state_t;

    localparam logic [2:0] DLAST = (CORE_LAT == 0) ? 3'd0 : 3'(CORE_LAT - 1);

    state_t     state;
    logic [5:0] n;
    logic [4:0] k;
    logic [2:0] s;
    logic [2:0] d;
    logic       accept;
    logic [2:0] nxt_s;
    logic [4:0] nxt_k;
    logic [5:0] nxt_a;

    function automatic logic [5:0] op_a(input logic [2:0] st, input logic [4:0] kx);
        logic [5:0] kk;
        logic [5:0] mask;
        kk   = {1'b0, kx};
        mask = (6'd1 << st) - 6'd1;
        return ((kk >> st) << (st + 3'd1)) | (kk & mask);
    endfunction

    function automatic logic [4:0] twid(input logic [2:0] st, input logic [4:0] kx);
        logic [4:0] mask;
        mask = 5'((6'd1 << st) - 6'd1);
        return 5'((kx & mask) << (3'd5 - st));
    endfunction

    assign rdy_o     = (state == IDLE) || (state == LOAD);
    assign accept    = val_i & rdy_o & ~rst;
    assign ld_we_o   = accept;
    assign ld_addr_o = {n[0], n[1], n[2], n[3], n[4], n[5]};
    assign busy_o    = (state != IDLE) | val_o;

    // Operands for the butterfly that would be issued on the coming edge.
    always_comb begin
        nxt_s = '0;
        nxt_k = '0;
        if (state == CALC && k != 5'd31) begin
            nxt_s = s;
            nxt_k = k + 5'd1;
        end else if (state == CALC || state == DRAIN) begin
            nxt_s = s + 3'd1;
        end
        nxt_a = op_a(nxt_s, nxt_k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            n           <= '0;
            k           <= '0;
            s           <= '0;
            d           <= '0;
            bf_val_o    <= 1'b0;
            bf_addr_a_o <= '0;
            bf_addr_b_o <= '0;
            bf_wn_idx_o <= '0;
            bf_stage_o  <= '0;
            rd_en_o     <= 1'b0;
            rd_addr_o   <= '0;
            val_o       <= 1'b0;
        end else begin
            val_o <= rd_en_o;
            case (state)
                IDLE: begin
                    if (accept) begin
                        n     <= n + 6'd1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        n <= n + 6'd1;
                        if (n == 6'd63) begin
                            state       <= CALC;
                            s           <= nxt_s;
                            k           <= nxt_k;
                            bf_val_o    <= 1'b1;
                            bf_addr_a_o <= nxt_a;
                            bf_addr_b_o <= nxt_a | (6'd1 << nxt_s);
                            bf_wn_idx_o <= twid(nxt_s, nxt_k);
                            bf_stage_o  <= nxt_s;
                        end
                    end
                end
                CALC: begin
                    if (k != 5'd31 || (CORE_LAT == 0 && s != 3'd5)) begin
                        s           <= nxt_s;
                        k           <= nxt_k;
                        bf_val_o    <= 1'b1;
                        bf_addr_a_o <= nxt_a;
                        bf_addr_b_o <= nxt_a | (6'd1 << nxt_s);
                        bf_wn_idx_o <= twid(nxt_s, nxt_k);
                        bf_stage_o  <= nxt_s;
                    end else if (CORE_LAT != 0) begin
                        bf_val_o <= 1'b0;
                        d        <= '0;
                        state    <= DRAIN;
                    end else begin
                        bf_val_o  <= 1'b0;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= '0;
                        state     <= OUT;
                    end
                end
                DRAIN: begin
                    if (d != DLAST) begin
                        d <= d + 3'd1;
                    end else if (s != 3'd5) begin
                        state       <= CALC;
                        s           <= nxt_s;
                        k           <= nxt_k;
                        bf_val_o    <= 1'b1;
                        bf_addr_a_o <= nxt_a;
                        bf_addr_b_o <= nxt_a | (6'd1 << nxt_s);
                        bf_wn_idx_o <= twid(nxt_s, nxt_k);
                        bf_stage_o  <= nxt_s;
                    end else begin
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= '0;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (rd_addr_o == 6'd63) begin
                        rd_en_o <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        rd_addr_o <= rd_addr_o + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back mirrors the issue stream through a CORE_LAT-deep delay line.
    if (CORE_LAT == 0) begin : g_wb_direct
        assign wb_val_o    = bf_val_o;
        assign wb_addr_a_o = bf_addr_a_o;
        assign wb_addr_b_o = bf_addr_b_o;
    end else begin : g_wb_delay
        logic [CORE_LAT-1:0] v_q;
        logic [5:0]          a_q [CORE_LAT];
        logic [5:0]          b_q [CORE_LAT];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= '0;
                for (int unsigned i = 0; i < CORE_LAT; i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                end
            end else begin
                v_q[0] <= bf_val_o;
                a_q[0] <= bf_addr_a_o;
                b_q[0] <= bf_addr_b_o;
                for (int unsigned i = 1; i < CORE_LAT; i++) begin
                    v_q[i] <= v_q[i-1];
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                end
            end
        end

        assign wb_val_o    = v_q[CORE_LAT-1];
        assign wb_addr_a_o = a_q[CORE_LAT-1];
        assign wb_addr_b_o = b_q[CORE_LAT-1];
    end

`ifdef FFT64_SCHED_SCALE_EN
    assign scale_o = bf_val_o;
`else
    assign scale_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft64_sched.sv
// Self-checking bench for fft64_sched: schedule model built from stage/issue arithmetic.
module tb_fft64_sched;

    localparam int LAT = 2;
    localparam int PER = 32 + LAT;
    localparam int T0  = 6 * PER;
    localparam int NT  = T0 + 70;
`ifdef FFT64_SCHED_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       val_i;
    logic       rdy_o;
    logic       ld_we_o;
    logic [5:0] ld_addr_o;
    logic       bf_val_o;
    logic [5:0] bf_addr_a_o;
    logic [5:0] bf_addr_b_o;
    logic [4:0] bf_wn_idx_o;
    logic [2:0] bf_stage_o;
    logic       wb_val_o;
    logic [5:0] wb_addr_a_o;
    logic [5:0] wb_addr_b_o;
    logic       scale_o;
    logic       rd_en_o;
    logic [5:0] rd_addr_o;
    logic       val_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    int wb_hold_a = 0;
    int wb_hold_b = 0;

    fft64_sched #(.CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .val_i(val_i), .rdy_o(rdy_o),
        .ld_we_o(ld_we_o), .ld_addr_o(ld_addr_o),
        .bf_val_o(bf_val_o), .bf_addr_a_o(bf_addr_a_o), .bf_addr_b_o(bf_addr_b_o),
        .bf_wn_idx_o(bf_wn_idx_o), .bf_stage_o(bf_stage_o),
        .wb_val_o(wb_val_o), .wb_addr_a_o(wb_addr_a_o), .wb_addr_b_o(wb_addr_b_o),
        .scale_o(scale_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .val_o(val_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst   = 1'b1;
        val_i = 1'b1;
        #1;
        total++;
        if ({ld_we_o, ld_addr_o, bf_val_o, bf_addr_a_o, bf_addr_b_o, bf_wn_idx_o, bf_stage_o,
             wb_val_o, wb_addr_a_o, wb_addr_b_o, scale_o, rd_en_o, rd_addr_o, val_o, busy_o} !== '0
            || rdy_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b ld_we=%b bf_val=%b wb_val=%b rd_en=%b val=%b busy=%b, required rdy=1 rest 0",
                     rdy_o, ld_we_o, bf_val_o, wb_val_o, rd_en_o, val_o, busy_o);
        end
        repeat (2) @(negedge clk);
        val_i = 1'b0;
        rst   = 1'b0;
        wb_hold_a = 0;
        wb_hold_b = 0;
    endtask

    // mode 0: back-to-back, 1: alternate 1/0, 2: random gaps
    task automatic load_frame(input int mode);
        int cnt = 0;
        int pulses = 0;
        int cyc = 0;
        logic v;
        logic [5:0] cv;
        logic [5:0] rev;
        while (cnt < 64 && cyc < 2000) begin
            @(negedge clk);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            val_i = v;
            #1;
            total++;
            if (rdy_o !== 1'b1 || ld_we_o !== v || busy_o !== (cnt > 0)) begin
                bad++;
                $display("FAIL load_ctrl: n=%0d got rdy=%b we=%b busy=%b, required rdy=1 we=%b busy=%b",
                         cnt, rdy_o, ld_we_o, busy_o, v, cnt > 0);
            end
            if (v) begin
                cv = 6'(cnt);
                for (int i = 0; i < 6; i++) rev[i] = cv[5-i];
                total++;
                if (ld_addr_o !== rev) begin
                    bad++;
                    $display("FAIL load_addr: n=%0d got %0d required %0d", cnt, ld_addr_o, rev);
                end
                cnt++;
            end
            if (ld_we_o === 1'b1) pulses++;
            cyc++;
        end
        total++;
        if (pulses != 64) begin
            bad++;
            $display("FAIL load_pulses: got %0d required 64", pulses);
        end
    endtask

    // Walks one transform from the cycle after the 64th sample; asserts rst at abort_at if >= 0.
    task automatic run_transform(input int abort_at);
        bit  hv [NT];
        int  ha [NT];
        int  hb [NT];
        int  st, w, h;
        int  la = 0, lb = 0, lwn = 0, lst = 0;
        int  ewa, ewb, sc_cnt = 0;
        int  spa, spb, spw;
        bit  ev, ewv, erd, evo;
        for (int t = 0; t < NT; t++) begin
            @(negedge clk);
            val_i = (t < T0 + 64);
            #1;
            st = t / PER;
            w  = t % PER;
            ev = (st < 6) && (w < 32);
            if (ev) begin
                h   = 1 << st;
                la  = (w / h) * 2 * h + (w % h);
                lb  = la + h;
                lwn = (w % h) * (32 / h);
                lst = st;
            end
            hv[t] = ev;
            ha[t] = la;
            hb[t] = lb;
            if (t >= LAT) begin
                ewv = hv[t-LAT]; ewa = ha[t-LAT]; ewb = hb[t-LAT];
            end else begin
                ewv = 1'b0; ewa = wb_hold_a; ewb = wb_hold_b;
            end
            erd = (t >= T0) && (t < T0 + 64);
            evo = (t >= T0 + 1) && (t < T0 + 65);

            total++;
            if (bf_val_o !== ev || {bf_addr_a_o, bf_addr_b_o, bf_wn_idx_o, bf_stage_o} !==
                {6'(la), 6'(lb), 5'(lwn), 3'(lst)}) begin
                bad++;
                $display("FAIL bf_issue: t=%0d got v=%b a=%0d b=%0d wn=%0d s=%0d required v=%b a=%0d b=%0d wn=%0d s=%0d",
                         t, bf_val_o, bf_addr_a_o, bf_addr_b_o, bf_wn_idx_o, bf_stage_o, ev, la, lb, lwn, lst);
            end
            if (t == 0 || t == PER + 1 || t == 5 * PER + 1 || t == 5 * PER + 31) begin
                if (t == 0)               begin spa = 0;  spb = 1;  spw = 0;  end
                else if (t == PER + 1)    begin spa = 1;  spb = 3;  spw = 16; end
                else if (t == 5 * PER + 1) begin spa = 1; spb = 33; spw = 1;  end
                else                      begin spa = 31; spb = 63; spw = 31; end
                total++;
                if ({bf_addr_a_o, bf_addr_b_o, bf_wn_idx_o} !== {6'(spa), 6'(spb), 5'(spw)}) begin
                    bad++;
                    $display("FAIL stage_spot: t=%0d got a=%0d b=%0d wn=%0d required a=%0d b=%0d wn=%0d",
                             t, bf_addr_a_o, bf_addr_b_o, bf_wn_idx_o, spa, spb, spw);
                end
            end
            total++;
            if (wb_val_o !== ewv || wb_addr_a_o !== 6'(ewa) || wb_addr_b_o !== 6'(ewb)) begin
                bad++;
                $display("FAIL writeback: t=%0d got v=%b a=%0d b=%0d required v=%b a=%0d b=%0d",
                         t, wb_val_o, wb_addr_a_o, wb_addr_b_o, ewv, ewa, ewb);
            end
            total++;
            if (scale_o !== (ev & SCALE_ON)) begin
                bad++;
                $display("FAIL scale: t=%0d got %b required %b", t, scale_o, ev & SCALE_ON);
            end
            if (scale_o === 1'b1) sc_cnt++;
            total++;
            if (rd_en_o !== erd || (erd && rd_addr_o !== 6'(t - T0)) || val_o !== evo) begin
                bad++;
                $display("FAIL readout: t=%0d got rd_en=%b addr=%0d val=%b required rd_en=%b addr=%0d val=%b",
                         t, rd_en_o, rd_addr_o, val_o, erd, t - T0, evo);
            end
            total++;
            if (busy_o !== (t < T0 + 65) || rdy_o !== (t >= T0 + 64) || ld_we_o !== 1'b0) begin
                bad++;
                $display("FAIL status: t=%0d got busy=%b rdy=%b we=%b required busy=%b rdy=%b we=0",
                         t, busy_o, rdy_o, ld_we_o, t < T0 + 65, t >= T0 + 64);
            end
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                return;
            end
        end
        total++;
        if (sc_cnt != (SCALE_ON ? 192 : 0)) begin
            bad++;
            $display("FAIL scale_count: got %0d required %0d", sc_cnt, SCALE_ON ? 192 : 0);
        end
        wb_hold_a = la;
        wb_hold_b = lb;
        val_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_frame(0);
        run_transform(-1);
    endtask

    task automatic test_toggle();
        load_frame(1);
        run_transform(-1);
    endtask

    task automatic test_abort();
        load_frame(2);
        run_transform(3 * PER + 10);
        total++;
        if ({bf_val_o, wb_val_o, rd_en_o, val_o, ld_we_o, scale_o, busy_o} !== '0 || rdy_o !== 1'b1
            || {bf_addr_a_o, bf_addr_b_o, wb_addr_a_o, wb_addr_b_o} !== '0) begin
            bad++;
            $display("FAIL abort_now: got bf=%b wb=%b rd=%b val=%b busy=%b rdy=%b required strobes 0 busy=0 rdy=1",
                     bf_val_o, wb_val_o, rd_en_o, val_o, busy_o, rdy_o);
        end
        val_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb_hold_a = 0;
        wb_hold_b = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            total++;
            if ({bf_val_o, wb_val_o, rd_en_o, val_o, ld_we_o, busy_o} !== '0) begin
                bad++;
                $display("FAIL abort_quiet: t=%0d got bf=%b wb=%b rd=%b val=%b we=%b busy=%b required all 0",
                         t, bf_val_o, wb_val_o, rd_en_o, val_o, ld_we_o, busy_o);
            end
        end
        load_frame(0);
        run_transform(-1);
    endtask

    initial begin
        rst   = 1'b0;
        val_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_toggle();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
